// File: rtl/falcon_vec_modsub.sv
// Streams (A[i] - B[i]) mod 12289 from two synchronous-read coefficient RAMs
// into a result RAM, one coefficient per cycle, with a two-stage read pipeline.

module falcon_modsub (
  input  logic [13:0] a,
  input  logic [13:0] b,
  output logic [13:0] y
);

  localparam logic [13:0] Q = 14'd12289;

  // The 14-bit wrap of a - b + Q lands back in range because the true result is below 2^14.
  always_comb begin
    if (a >= b) y = a - b;
    else        y = a - b + Q;
  end

endmodule

module falcon_vec_modsub #(
  parameter int N  = 512,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [13:0]   a_data,
  input  logic [13:0]   b_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [13:0]   wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state;
  logic          v1;
  logic [AW-1:0] a1;
  logic [13:0]   diff;

  falcon_modsub u_modsub (
    .a(a_data),
    .b(b_data),
    .y(diff)
  );

  // rd_addr doubles as the read counter. Stage 1 (v1/a1) lines up with the RAM
  // output; stage 2 is the registered write port itself, so wr_en is its valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      v1      <= 1'b0;
      a1      <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      v1    <= rd_en;
      a1    <= rd_addr;
      wr_en <= v1;
      if (v1) begin
        wr_addr <= a1;
        wr_data <= diff;
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state   <= RUN;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr == LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        // Stage 2 empties on the same edge stage 1 is seen empty, so both are clear next cycle.
        DRAIN: begin
          if (!v1) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Cancelling kills in-flight writes too, so the result RAM sees nothing more.
      if (abort && (state == RUN || state == DRAIN)) begin
        state   <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
        rd_en   <= 1'b0;
        rd_addr <= '0;
        v1      <= 1'b0;
        wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_falcon_vec_modsub.sv
// Directed bench for falcon_vec_modsub: an N=8 instance for timing scenarios and
// an N=512 instance for random-data passes, each backed by behavioural RAMs.

module tb_falcon_vec_modsub;

  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int NL  = 512;
  localparam int AWL = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [13:0]   a_data = '0, b_data = '0, wr_data;

  logic           start_l = 1'b0, abort_l = 1'b0;
  logic           busy_l, done_l, rd_en_l, wr_en_l;
  logic [AWL-1:0] rd_addr_l, wr_addr_l;
  logic [13:0]    a_data_l = '0, b_data_l = '0, wr_data_l;

  logic [13:0] mem_a [N];
  logic [13:0] mem_b [N];
  logic [13:0] exp_c [N];
  logic [13:0] mem_al [NL];
  logic [13:0] mem_bl [NL];

  int nvec = 0;
  int nerr = 0;

  falcon_vec_modsub #(.N(N), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_data(a_data), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  falcon_vec_modsub #(.N(NL), .AW(AWL)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .start(start_l), .abort(abort_l),
    .busy(busy_l), .done(done_l), .rd_en(rd_en_l), .rd_addr(rd_addr_l),
    .a_data(a_data_l), .b_data(b_data_l),
    .wr_en(wr_en_l), .wr_addr(wr_addr_l), .wr_data(wr_data_l)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
    if (rd_en_l) begin
      a_data_l <= mem_al[rd_addr_l];
      b_data_l <= mem_bl[rd_addr_l];
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data} !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_n8: got %b expected all zero", {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data});
    end
    nvec++;
    if ({busy_l, done_l, rd_en_l, rd_addr_l, wr_en_l, wr_addr_l, wr_data_l} !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_n512: got %b expected all zero", {busy_l, done_l, rd_en_l, rd_addr_l, wr_en_l, wr_addr_l, wr_data_l});
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
      nerr++;
      $display("[TB] FAIL idle_after_reset: got %b expected 0000", {busy, done, rd_en, wr_en});
    end
  endtask

  task automatic test_basic();
    logic eb, ed, er, ew;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      er = (k <= N);
      ew = (k >= 3 && k <= N + 2);
      eb = (k <= N + 2);
      ed = (k == N + 3);
      nvec++;
      if ({busy, done, rd_en, wr_en} !== {eb, ed, er, ew}) begin
        nerr++;
        $display("[TB] FAIL basic_ctrl cycle %0d: busy/done/rd_en/wr_en got %b expected %b", k, {busy, done, rd_en, wr_en}, {eb, ed, er, ew});
      end
      if (er) begin
        nvec++;
        if (rd_addr !== AW'(k - 1)) begin
          nerr++;
          $display("[TB] FAIL basic_rd_addr cycle %0d: got %0d expected %0d", k, rd_addr, k - 1);
        end
      end
      if (ew) begin
        nvec++;
        if (wr_addr !== AW'(k - 3) || wr_data !== exp_c[k - 3]) begin
          nerr++;
          $display("[TB] FAIL basic_write cycle %0d: got addr %0d data %0d expected addr %0d data %0d", k, wr_addr, wr_data, k - 3, exp_c[k - 3]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic eb, ed, er, ew;
    int kk, nw;
    nw = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 2 * (N + 4); k++) begin
      kk = (k - 1) % (N + 4) + 1;
      er = (kk <= N);
      ew = (kk >= 3 && kk <= N + 2);
      eb = (kk <= N + 2);
      ed = (kk == N + 3);
      if (wr_en) nw++;
      nvec++;
      if ({busy, done, rd_en, wr_en} !== {eb, ed, er, ew}) begin
        nerr++;
        $display("[TB] FAIL b2b_ctrl cycle %0d: got %b expected %b", k, {busy, done, rd_en, wr_en}, {eb, ed, er, ew});
      end
      if (er) begin
        nvec++;
        if (rd_addr !== AW'(kk - 1)) begin
          nerr++;
          $display("[TB] FAIL b2b_rd_addr cycle %0d: got %0d expected %0d", k, rd_addr, kk - 1);
        end
      end
      if (ew) begin
        nvec++;
        if (wr_addr !== AW'(kk - 3) || wr_data !== exp_c[kk - 3]) begin
          nerr++;
          $display("[TB] FAIL b2b_write cycle %0d: got addr %0d data %0d expected addr %0d data %0d", k, wr_addr, wr_data, kk - 3, exp_c[kk - 3]);
        end
      end
      if (k == N + 4) start = 1'b1;
      if (k == N + 5) start = 1'b0;
      @(posedge clk);
      #1;
    end
    nvec++;
    if (nw !== 2 * N) begin
      nerr++;
      $display("[TB] FAIL b2b_write_count: got %0d expected %0d", nw, 2 * N);
    end
  endtask

  task automatic test_start_ignored();
    int nw, nd;
    nw = 0;
    nd = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= N + 8; k++) begin
      if (wr_en) nw++;
      if (done) nd++;
      nvec++;
      if (busy !== (k <= N + 2)) begin
        nerr++;
        $display("[TB] FAIL ignore_busy cycle %0d: got %b expected %b", k, busy, (k <= N + 2));
      end
      if (k == N + 3) begin
        nvec++;
        if (done !== 1'b1) begin
          nerr++;
          $display("[TB] FAIL abort_in_done_pulse: got done %b expected 1", done);
        end
      end
      if (k >= N + 4) begin
        nvec++;
        if ({done, rd_en} !== 2'b00) begin
          nerr++;
          $display("[TB] FAIL ignore_after_done cycle %0d: done/rd_en got %b expected 00", k, {done, rd_en});
        end
      end
      if (k == 3 || k == N + 1) start = 1'b1;
      if (k == 4 || k == N + 2) start = 1'b0;
      if (k == N + 3) begin
        start = 1'b1;
        abort = 1'b1;
      end
      if (k == N + 4) begin
        start = 1'b0;
        abort = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    nvec++;
    if (nw !== N || nd !== 1) begin
      nerr++;
      $display("[TB] FAIL ignore_counts: got %0d writes %0d dones expected %0d writes 1 done", nw, nd, N);
    end
  endtask

  task automatic test_abort();
    logic eb, er, ew;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      er = (k <= 4);
      ew = (k == 3 || k == 4);
      eb = (k <= 4);
      nvec++;
      if ({busy, done, rd_en, wr_en} !== {eb, 1'b0, er, ew}) begin
        nerr++;
        $display("[TB] FAIL abort_ctrl cycle %0d: got %b expected %b", k, {busy, done, rd_en, wr_en}, {eb, 1'b0, er, ew});
      end
      if (ew) begin
        nvec++;
        if (wr_addr !== AW'(k - 3) || wr_data !== exp_c[k - 3]) begin
          nerr++;
          $display("[TB] FAIL abort_write cycle %0d: got addr %0d data %0d expected addr %0d data %0d", k, wr_addr, wr_data, k - 3, exp_c[k - 3]);
        end
      end
      if (k == 4) abort = 1'b1;
      if (k == 5) abort = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({busy, rd_en, wr_en, done} !== 4'b0000) begin
        nerr++;
        $display("[TB] FAIL start_abort_idle cycle %0d: got %b expected 0000", k, {busy, rd_en, wr_en, done});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    logic eb, ed, er, ew;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    nvec++;
    if ({busy, rd_en, rd_addr, wr_en} !== {1'b1, 1'b1, AW'(4), 1'b1}) begin
      nerr++;
      $display("[TB] FAIL pre_reset_run: got %b expected %b", {busy, rd_en, rd_addr, wr_en}, {1'b1, 1'b1, AW'(4), 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data} !== '0) begin
      nerr++;
      $display("[TB] FAIL async_reset_outputs: got %b expected all zero", {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if ({busy, rd_en, wr_en, done} !== 4'b0000) begin
      nerr++;
      $display("[TB] FAIL post_reset_idle: got %b expected 0000", {busy, rd_en, wr_en, done});
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      er = (k <= N);
      ew = (k >= 3 && k <= N + 2);
      eb = (k <= N + 2);
      ed = (k == N + 3);
      nvec++;
      if ({busy, done, rd_en, wr_en} !== {eb, ed, er, ew}) begin
        nerr++;
        $display("[TB] FAIL rerun_ctrl cycle %0d: got %b expected %b", k, {busy, done, rd_en, wr_en}, {eb, ed, er, ew});
      end
      if (er) begin
        nvec++;
        if (rd_addr !== AW'(k - 1)) begin
          nerr++;
          $display("[TB] FAIL rerun_rd_addr cycle %0d: got %0d expected %0d", k, rd_addr, k - 1);
        end
      end
      if (ew) begin
        nvec++;
        if (wr_addr !== AW'(k - 3) || wr_data !== exp_c[k - 3]) begin
          nerr++;
          $display("[TB] FAIL rerun_write cycle %0d: got addr %0d data %0d expected addr %0d data %0d", k, wr_addr, wr_data, k - 3, exp_c[k - 3]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stress();
    logic eb, ed, er, ew;
    int r, nw;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NL; i++) begin
        mem_al[i] = 14'($urandom_range(0, 12288));
        mem_bl[i] = 14'($urandom_range(0, 12288));
      end
      mem_al[0] = 14'd0;     mem_bl[0] = 14'd12288;
      mem_al[1] = 14'd12288; mem_bl[1] = 14'd0;
      mem_al[2] = 14'd777;   mem_bl[2] = 14'd777;
      mem_al[NL - 1] = 14'd0; mem_bl[NL - 1] = 14'd1;
      nw = 0;
      start_l = 1'b1;
      @(posedge clk);
      #1 start_l = 1'b0;
      for (int k = 1; k <= NL + 4; k++) begin
        er = (k <= NL);
        ew = (k >= 3 && k <= NL + 2);
        eb = (k <= NL + 2);
        ed = (k == NL + 3);
        if (wr_en_l) nw++;
        nvec++;
        if ({busy_l, done_l, rd_en_l, wr_en_l} !== {eb, ed, er, ew}) begin
          nerr++;
          $display("[TB] FAIL stress_ctrl pass %0d cycle %0d: got %b expected %b", p, k, {busy_l, done_l, rd_en_l, wr_en_l}, {eb, ed, er, ew});
        end
        if (ew) begin
          r = (int'(mem_al[k - 3]) - int'(mem_bl[k - 3]) + 12289) % 12289;
          nvec++;
          if (wr_addr_l !== AWL'(k - 3) || wr_data_l !== 14'(r)) begin
            nerr++;
            $display("[TB] FAIL stress_write pass %0d cycle %0d: got addr %0d data %0d expected addr %0d data %0d", p, k, wr_addr_l, wr_data_l, k - 3, r);
          end
        end
        @(posedge clk);
        #1;
      end
      nvec++;
      if (nw !== NL) begin
        nerr++;
        $display("[TB] FAIL stress_write_count pass %0d: got %0d expected %0d", p, nw, NL);
      end
    end
  endtask

  initial begin
    mem_a = '{14'd5, 14'd12288, 14'd0, 14'd100, 14'd7, 14'd12288, 14'd1, 14'd0};
    mem_b = '{14'd7, 14'd0, 14'd12288, 14'd100, 14'd5, 14'd12288, 14'd0, 14'd1};
    exp_c = '{14'd12287, 14'd12288, 14'd1, 14'd0, 14'd2, 14'd0, 14'd1, 14'd12288};
    for (int i = 0; i < NL; i++) begin
      mem_al[i] = '0;
      mem_bl[i] = '0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_stress();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
